// File: rtl/cc_ingr_protocol_error_pkg.sv
// Shared definitions for the ingress protocol error logger: fault bit indices,
// the default implemented-bit mask and the first-error record states.
package cc_ingr_protocol_error_pkg;

  localparam int ERR_WIDTH = 16;

  localparam int RESP_CHANNEL_EQ_REQ      = 0;
  localparam int RESP_ID_EQ_REQ           = 1;
  localparam int RESP_ADDR_EQ_REQ         = 2;
  localparam int RESP_LEN_EQ_REQ          = 3;
  localparam int RESP_SIZE_EQ_REQ         = 4;
  localparam int RESP_TYPE_EQ_REQ         = 5;
  localparam int RESP_WITHOUT_REQ         = 6;
  localparam int RESP_ORDER_EQ_REQ        = 7;
  localparam int RESP_LAST_EQ_REQ         = 8;
  localparam int RESP_STATUS_LEGAL        = 9;
  localparam int RESP_TAG_EQ_REQ          = 12;
  localparam int RESP_BURST_LENGTH_EQ_REQ = 13;

  localparam logic [ERR_WIDTH-1:0] DEFAULT_VALID_BITS = 16'h33FF;

  typedef enum logic {
    FE_EMPTY = 1'b0,
    FE_HELD  = 1'b1
  } fe_state_e;

endpackage

// File: rtl/cc_sat_counter.sv
// Saturating occurrence counter; a clear coinciding with an increment leaves
// the count at one so the clearing cycle's event is not lost.
module cc_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? CNT_WIDTH'(1) : '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cc_ingr_protocol_error_logger.sv
// Turns protocol monitor fault pulses into sticky flags, per-bit counters,
// a first-error record with timestamp and a level interrupt.
module cc_ingr_protocol_error_logger
  import cc_ingr_protocol_error_pkg::*;
#(
  parameter int                   CNT_WIDTH  = 16,
  parameter int                   TS_WIDTH   = 32,
  parameter logic [ERR_WIDTH-1:0] VALID_BITS = DEFAULT_VALID_BITS
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic [15:0]          protocol_error,
  input  logic                 protocol_error_ap_vld,
  input  logic [15:0]          irq_enable,
  input  logic                 clear_req,
  input  logic [15:0]          clear_mask,
  input  logic [3:0]           cnt_sel,
  output logic [15:0]          error_sticky,
  output logic [CNT_WIDTH-1:0] cnt_value,
  output logic [15:0]          first_error,
  output logic [TS_WIDTH-1:0]  first_error_ts,
  output logic                 first_error_valid,
  output logic                 irq
);

  logic [ERR_WIDTH-1:0] ev;
  logic [ERR_WIDTH-1:0] clr_vec;
  logic                 full_clear;

  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [ERR_WIDTH-1:0] sticky_q, sticky_d;
  logic [ERR_WIDTH-1:0] fe_q, fe_d;
  logic [TS_WIDTH-1:0]  fe_ts_q, fe_ts_d;
  fe_state_e            state_q, state_d;
  logic                 irq_q, irq_d;
  logic [CNT_WIDTH-1:0] cnt_value_q, cnt_value_d;

  logic [CNT_WIDTH-1:0] cnt_arr [ERR_WIDTH];

  always_comb begin
    ev         = protocol_error_ap_vld ? (protocol_error & VALID_BITS) : '0;
    clr_vec    = clear_req ? clear_mask : '0;
    full_clear = clear_req && (clear_mask == 16'hFFFF);
  end

  for (genvar i = 0; i < ERR_WIDTH; i++) begin : g_cnt
    if (VALID_BITS[i]) begin : g_impl
      cc_sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
      ) u_cnt (
        .clk  (ap_clk),
        .rst  (ap_rst),
        .inc  (ev[i]),
        .clr  (clr_vec[i]),
        .count(cnt_arr[i])
      );
    end else begin : g_rsvd
      assign cnt_arr[i] = '0;
    end
  end

  // Set is OR-ed in after the clear so a same-cycle event always survives.
  always_comb begin
    ts_d        = ts_q + TS_WIDTH'(1);
    sticky_d    = (sticky_q & ~clr_vec) | ev;
    irq_d       = |(sticky_q & irq_enable);
    cnt_value_d = cnt_arr[cnt_sel];
  end

  always_comb begin
    state_d = state_q;
    fe_d    = fe_q;
    fe_ts_d = fe_ts_q;
    case (state_q)
      FE_EMPTY: begin
        if (ev != '0) begin
          fe_d    = ev;
          fe_ts_d = ts_q;
          state_d = FE_HELD;
        end
      end
      FE_HELD: begin
        // Only a full clear re-arms the record; partial clears leave it frozen.
        if (full_clear) begin
          if (ev != '0) begin
            fe_d    = ev;
            fe_ts_d = ts_q;
          end else begin
            fe_d    = '0;
            fe_ts_d = '0;
            state_d = FE_EMPTY;
          end
        end
      end
      default: begin
        state_d = FE_EMPTY;
      end
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      ts_q        <= '0;
      sticky_q    <= '0;
      fe_q        <= '0;
      fe_ts_q     <= '0;
      state_q     <= FE_EMPTY;
      irq_q       <= 1'b0;
      cnt_value_q <= '0;
    end else begin
      ts_q        <= ts_d;
      sticky_q    <= sticky_d;
      fe_q        <= fe_d;
      fe_ts_q     <= fe_ts_d;
      state_q     <= state_d;
      irq_q       <= irq_d;
      cnt_value_q <= cnt_value_d;
    end
  end

  assign error_sticky      = sticky_q;
  assign cnt_value         = cnt_value_q;
  assign first_error       = fe_q;
  assign first_error_ts    = fe_ts_q;
  assign first_error_valid = (state_q == FE_HELD);
  assign irq               = irq_q;

endmodule

// File: tb/tb_cc_ingr_protocol_error_logger.sv
// Self-checking bench for the protocol error logger: directed scenarios plus
// randomized traffic against a behavioural model of the logging rules.
module tb_cc_ingr_protocol_error_logger;

  localparam logic [15:0] VALID = 16'h33FF;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [15:0] protocol_error;
  logic        protocol_error_ap_vld;
  logic [15:0] irq_enable;
  logic        clear_req;
  logic [15:0] clear_mask;
  logic [3:0]  cnt_sel;

  logic [15:0] error_sticky;
  logic [15:0] cnt_value;
  logic [15:0] first_error;
  logic [31:0] first_error_ts;
  logic        first_error_valid;
  logic        irq;

  logic [15:0] error_sticky4;
  logic [3:0]  cnt_value4;
  logic [15:0] first_error4;
  logic [31:0] first_error_ts4;
  logic        first_error_valid4;
  logic        irq4;

  int tests = 0;
  int fails = 0;

  // behavioural model state
  logic [15:0] m_sticky;
  int          m_count  [16];
  int          m_count4 [16];
  logic [15:0] m_fe;
  logic [31:0] m_fets;
  logic        m_valid;
  logic        m_irq;
  logic [15:0] m_cnt;
  logic [3:0]  m_cnt4;
  logic [31:0] m_ts;

  always #5 ap_clk = ~ap_clk;

  cc_ingr_protocol_error_logger dut (
    .ap_clk               (ap_clk),
    .ap_rst               (ap_rst),
    .protocol_error       (protocol_error),
    .protocol_error_ap_vld(protocol_error_ap_vld),
    .irq_enable           (irq_enable),
    .clear_req            (clear_req),
    .clear_mask           (clear_mask),
    .cnt_sel              (cnt_sel),
    .error_sticky         (error_sticky),
    .cnt_value            (cnt_value),
    .first_error          (first_error),
    .first_error_ts       (first_error_ts),
    .first_error_valid    (first_error_valid),
    .irq                  (irq)
  );

  cc_ingr_protocol_error_logger #(.CNT_WIDTH(4)) dut4 (
    .ap_clk               (ap_clk),
    .ap_rst               (ap_rst),
    .protocol_error       (protocol_error),
    .protocol_error_ap_vld(protocol_error_ap_vld),
    .irq_enable           (irq_enable),
    .clear_req            (clear_req),
    .clear_mask           (clear_mask),
    .cnt_sel              (cnt_sel),
    .error_sticky         (error_sticky4),
    .cnt_value            (cnt_value4),
    .first_error          (first_error4),
    .first_error_ts       (first_error_ts4),
    .first_error_valid    (first_error_valid4),
    .irq                  (irq4)
  );

  // Reference model: applies the logging rules to the inputs seen at each edge.
  always @(posedge ap_clk or posedge ap_rst) begin
    logic [15:0] ev;
    logic [15:0] cm;
    if (ap_rst) begin
      m_sticky = '0;
      m_fe     = '0;
      m_fets   = '0;
      m_valid  = 1'b0;
      m_irq    = 1'b0;
      m_cnt    = '0;
      m_cnt4   = '0;
      m_ts     = '0;
      for (int i = 0; i < 16; i++) begin
        m_count[i]  = 0;
        m_count4[i] = 0;
      end
    end else begin
      ev = protocol_error_ap_vld ? (protocol_error & VALID) : 16'h0;
      cm = clear_req ? clear_mask : 16'h0;
      m_irq  = |(m_sticky & irq_enable);
      m_cnt  = VALID[cnt_sel] ? 16'(m_count[cnt_sel]) : 16'h0;
      m_cnt4 = VALID[cnt_sel] ? 4'(m_count4[cnt_sel]) : 4'h0;
      for (int i = 0; i < 16; i++) begin
        if (VALID[i]) begin
          if (cm[i]) begin
            m_count[i]  = ev[i] ? 1 : 0;
            m_count4[i] = ev[i] ? 1 : 0;
          end else if (ev[i]) begin
            m_count[i]  = (m_count[i]  < 65535) ? m_count[i] + 1  : 65535;
            m_count4[i] = (m_count4[i] < 15)    ? m_count4[i] + 1 : 15;
          end
        end
      end
      m_sticky = (m_sticky & ~cm) | ev;
      if (ev != 16'h0 && (!m_valid || cm == 16'hFFFF)) begin
        m_fe    = ev;
        m_fets  = m_ts;
        m_valid = 1'b1;
      end else if (cm == 16'hFFFF) begin
        m_fe    = '0;
        m_fets  = '0;
        m_valid = 1'b0;
      end
      m_ts = m_ts + 32'd1;
    end
  end

  task automatic cycle(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge ap_clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    protocol_error        = '0;
    protocol_error_ap_vld = 1'b0;
    clear_req             = 1'b0;
    clear_mask            = '0;
  endtask

  task automatic full_clear();
    clear_req  = 1'b1;
    clear_mask = 16'hFFFF;
    cycle();
    clear_req  = 1'b0;
    clear_mask = '0;
  endtask

  task automatic test_reset();
    int bad;
    ap_rst     = 1'b1;
    irq_enable = '0;
    cnt_sel    = '0;
    idle_inputs();
    cycle(3);
    tests++;
    if ({error_sticky, cnt_value, first_error, first_error_ts, first_error_valid, irq} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got sticky=%h cnt=%h fe=%h ts=%h v=%b irq=%b, want all 0",
               error_sticky, cnt_value, first_error, first_error_ts, first_error_valid, irq);
    end
    ap_rst     = 1'b0;
    irq_enable = 16'hFFFF;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      cycle();
      if ({error_sticky, cnt_value, first_error, first_error_ts, first_error_valid, irq} !== '0)
        bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("[TB] FAIL idle_outputs: %0d nonzero cycles observed, want 0", bad);
    end
    protocol_error        = 16'h0008;
    protocol_error_ap_vld = 1'b1;
    cycle();
    idle_inputs();
    tests++;
    if (first_error_ts !== 32'd100 || first_error !== 16'h0008 || first_error_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL first_ts: got ts=%0d fe=%h v=%b, want ts=100 fe=0008 v=1",
               first_error_ts, first_error, first_error_valid);
    end
  endtask

  task automatic test_irq_accum();
    irq_enable = 16'h0040;
    full_clear();
    protocol_error        = 16'h0040;
    protocol_error_ap_vld = 1'b1;
    cycle(3);
    protocol_error = 16'h0200;
    cycle();
    idle_inputs();
    cnt_sel = 4'd6;
    cycle(2);
    tests++;
    if (cnt_value !== 16'd3 || error_sticky !== 16'h0240 || first_error !== 16'h0040 || irq !== 1'b1) begin
      fails++;
      $display("[TB] FAIL accum_bit6: got cnt=%0d sticky=%h fe=%h irq=%b, want cnt=3 sticky=0240 fe=0040 irq=1",
               cnt_value, error_sticky, first_error, irq);
    end
    cnt_sel = 4'd9;
    cycle(2);
    tests++;
    if (cnt_value !== 16'd1) begin
      fails++;
      $display("[TB] FAIL accum_bit9: got cnt=%0d, want 1", cnt_value);
    end
    irq_enable = 16'h0001;
    cycle(2);
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("[TB] FAIL irq_masked: got irq=%b, want 0", irq);
    end
  endtask

  task automatic test_all_bits();
    protocol_error        = 16'hFFFF;
    protocol_error_ap_vld = 1'b1;
    cycle();
    idle_inputs();
    cnt_sel = 4'd10;
    cycle(2);
    tests++;
    if (error_sticky !== 16'h33FF || cnt_value !== 16'd0 || cnt_value4 !== 4'd0) begin
      fails++;
      $display("[TB] FAIL all_bits: got sticky=%h cnt10=%0d cnt10w4=%0d, want sticky=33FF cnt10=0",
               error_sticky, cnt_value, cnt_value4);
    end
  endtask

  task automatic test_no_vld();
    logic [15:0] s_sticky, s_fe, s_cnt;
    logic [31:0] s_fets;
    logic        s_valid;
    cnt_sel  = 4'd0;
    cycle(2);
    s_sticky = m_sticky;
    s_fe     = m_fe;
    s_fets   = m_fets;
    s_valid  = m_valid;
    s_cnt    = 16'(m_count[0]);
    protocol_error        = 16'h0001;
    protocol_error_ap_vld = 1'b0;
    cycle(3);
    idle_inputs();
    tests++;
    if ({error_sticky, cnt_value, first_error, first_error_ts, first_error_valid} !==
        {s_sticky, s_cnt, s_fe, s_fets, s_valid}) begin
      fails++;
      $display("[TB] FAIL no_vld: got sticky=%h cnt=%0d fe=%h ts=%0d v=%b, want sticky=%h cnt=%0d fe=%h ts=%0d v=%b",
               error_sticky, cnt_value, first_error, first_error_ts, first_error_valid,
               s_sticky, s_cnt, s_fe, s_fets, s_valid);
    end
  endtask

  task automatic test_saturation();
    full_clear();
    cnt_sel               = 4'd0;
    protocol_error        = 16'h0001;
    protocol_error_ap_vld = 1'b1;
    cycle(20);
    idle_inputs();
    cycle(2);
    tests++;
    if (cnt_value4 !== 4'd15) begin
      fails++;
      $display("[TB] FAIL saturate_w4: got cnt=%0d, want 15", cnt_value4);
    end
    tests++;
    if (cnt_value !== 16'd20) begin
      fails++;
      $display("[TB] FAIL count_w16: got cnt=%0d, want 20", cnt_value);
    end
  endtask

  task automatic test_clear_collision();
    logic [31:0] exp_ts;
    cnt_sel = 4'd2;
    cycle();
    exp_ts                = m_ts;
    clear_req             = 1'b1;
    clear_mask            = 16'hFFFF;
    protocol_error        = 16'h0004;
    protocol_error_ap_vld = 1'b1;
    cycle();
    idle_inputs();
    tests++;
    if (error_sticky !== 16'h0004 || first_error !== 16'h0004 || first_error_ts !== exp_ts ||
        first_error_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL collision: got sticky=%h fe=%h ts=%0d v=%b, want sticky=0004 fe=0004 ts=%0d v=1",
               error_sticky, first_error, first_error_ts, first_error_valid, exp_ts);
    end
    clear_req  = 1'b1;
    clear_mask = 16'h0004;
    cycle();
    idle_inputs();
    tests++;
    if (cnt_value !== 16'd1 || error_sticky !== 16'h0000 || first_error !== 16'h0004 ||
        first_error_ts !== exp_ts || first_error_valid !== 1'b1) begin
      fails++;
      $display("[TB] FAIL partial_clear: got cnt=%0d sticky=%h fe=%h ts=%0d v=%b, want cnt=1 sticky=0000 fe=0004 ts=%0d v=1",
               cnt_value, error_sticky, first_error, first_error_ts, first_error_valid, exp_ts);
    end
    cycle();
    tests++;
    if (cnt_value !== 16'd0) begin
      fails++;
      $display("[TB] FAIL cleared_count: got cnt=%0d, want 0", cnt_value);
    end
  endtask

  task automatic test_back_to_back();
    int bad  = 0;
    int bad4 = 0;
    for (int c = 0; c < 400; c++) begin
      protocol_error        = 16'($urandom) & 16'($urandom);
      protocol_error_ap_vld = ($urandom_range(0, 3) != 0);
      clear_req             = ($urandom_range(0, 7) == 0);
      clear_mask            = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom);
      cnt_sel               = 4'($urandom);
      if ($urandom_range(0, 15) == 0) irq_enable = 16'($urandom);
      if (c == 200) begin
        ap_rst = 1'b1;
        #1;
        cycle();
        ap_rst = 1'b0;
      end else begin
        cycle();
      end
      if ({error_sticky, cnt_value, first_error, first_error_ts, first_error_valid, irq} !==
          {m_sticky, m_cnt, m_fe, m_fets, m_valid, m_irq}) begin
        bad++;
        if (bad <= 5)
          $display("[TB] FAIL random_w16 cycle %0d: got sticky=%h cnt=%h fe=%h ts=%h v=%b irq=%b, want sticky=%h cnt=%h fe=%h ts=%h v=%b irq=%b",
                   c, error_sticky, cnt_value, first_error, first_error_ts, first_error_valid, irq,
                   m_sticky, m_cnt, m_fe, m_fets, m_valid, m_irq);
      end
      if ({error_sticky4, cnt_value4, first_error4, first_error_ts4, first_error_valid4, irq4} !==
          {m_sticky, m_cnt4, m_fe, m_fets, m_valid, m_irq}) begin
        bad4++;
        if (bad4 <= 5)
          $display("[TB] FAIL random_w4 cycle %0d: got sticky=%h cnt=%h fe=%h v=%b irq=%b, want sticky=%h cnt=%h fe=%h v=%b irq=%b",
                   c, error_sticky4, cnt_value4, first_error4, first_error_valid4, irq4,
                   m_sticky, m_cnt4, m_fe, m_valid, m_irq);
      end
    end
    idle_inputs();
    tests++;
    if (bad != 0) fails++;
    tests++;
    if (bad4 != 0) fails++;
  endtask

  initial begin
    test_reset();
    test_irq_accum();
    test_all_bits();
    test_no_vld();
    test_saturation();
    test_clear_collision();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cc_ingr_protocol_error_logger.md
# cc_ingr_protocol_error_logger

Downstream consumer of the ingress protocol monitor's `protocol_error` / `protocol_error_ap_vld` stream. It turns per-cycle fault pulses into state that software can read:
- sticky per-bit error flags;
- saturating per-bit occurrence counters;
- a first-error record (bits plus timestamp);
- a level interrupt.

It sits between the monitor and the chain-control CSR block, which drives the clear/select inputs and reads the outputs.

## Interface
Parameters:
- `CNT_WIDTH`, 16: width of each per-bit saturating counter.
- `TS_WIDTH`, 32: width of the free-running cycle timestamp.
- `VALID_BITS`, 16'h33FF: implemented fault bits. Bits 10, 11, 14 and 15 are reserved and ignored.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - `ap_clk`  in  1  clock.
  - `ap_rst`  in  1  asynchronous, active-high reset.
- Fault input from the monitor:
  - `protocol_error`  in  16  fault bit vector.
  - `protocol_error_ap_vld`  in  1  qualifies `protocol_error`.
- Control from the CSR block:
  - `irq_enable`  in  16  per-bit interrupt enable.
  - `clear_req`  in  1  single-cycle clear strobe.
  - `clear_mask`  in  16  write-1-to-clear bit select, sampled with `clear_req`.
  - `cnt_sel`  in  4  counter read index.
- Outputs:
  - `error_sticky`  out  16  latched fault bits.
  - `cnt_value`  out  `CNT_WIDTH`  counter selected by `cnt_sel`.
  - `first_error`  out  16  fault bits of the first recorded event.
  - `first_error_ts`  out  `TS_WIDTH`  timestamp of the first recorded event.
  - `first_error_valid`  out  1  first-error record is held.
  - `irq`  out  1  level interrupt.

## Operation
- Effective event: `ev = protocol_error & VALID_BITS` when `protocol_error_ap_vld` = 1, otherwise 0. Input bits with `ap_vld` low are ignored.
- Timestamp: a `TS_WIDTH` free-running counter increments every cycle and wraps modulo 2^TS_WIDTH. The value sampled is the one present in the event cycle.
- Sticky flags: `error_sticky <= (error_sticky & ~(clear_req ? clear_mask : 0)) | ev`.
  - Set wins over a same-cycle clear of the same bit.
- Per-bit counters: for each i in VALID_BITS,
  - `ev[i]` → counter[i] + 1, saturating at 2^CNT_WIDTH−1 (never wraps);
  - `clear_req & clear_mask[i]` → counter[i] = 0;
  - both in the same cycle → counter[i] = 1.
  - Reserved bits: counter is constant 0.
- First-error FSM, two states:
  - EMPTY: `first_error_valid` = 0. On `ev` ≠ 0, capture `first_error = ev` and `first_error_ts = ts`, then go to HELD.
  - HELD: record frozen; later events do not overwrite it. `clear_req` with `clear_mask` = 16'hFFFF returns to EMPTY and zeroes the record. If `ev` ≠ 0 in that same cycle, capture the new event and stay in HELD.
  - A partial `clear_mask` has no effect on the record.
- Interrupt: `irq = |(error_sticky & irq_enable)`, registered. `irq_enable` does not gate latching.
- Counter read: `cnt_value` is the registered `counter[cnt_sel]`. A reserved or unimplemented index reads 0.

## Timing
- Reset (asynchronous assert, synchronous to `ap_clk` on release): all outputs 0, FSM in EMPTY, timestamp 0, all counters 0.
- Event in cycle N → `error_sticky`, counters, first-error record and `first_error_valid` update at edge N+1. `irq` updates at edge N+2.
- Clear in cycle N → state effective at N+1; `irq` falls at N+2.
- `cnt_sel` change in cycle N → `cnt_value` reflects it at N+1. A count that changes in cycle N is visible at N+2.
- `clear_req` is a level sampled every cycle. The CSR block must pulse it for exactly one cycle. Holding it high clears repeatedly, which is legal.
- Events may arrive back-to-back every cycle; none is dropped.
- Reset asserted mid-operation discards all state. Events in the reset cycle are lost.

## Structure
- Shared package `cc_ingr_protocol_error_pkg` holds:
  - fault bit index localparams (0 `RESP_CHANNEL_EQ_REQ` … 13 `RESP_BURST_LENGTH_EQ_REQ`);
  - the default `VALID_BITS` mask;
  - the width constant 16 for the fault vector.
- One sub-module, `cc_sat_counter`: a `CNT_WIDTH` saturating counter with `inc` and `clr` inputs, where `clr` with `inc` gives 1. It is instantiated per implemented bit via generate.
- The FSM, timestamp counter, sticky register and read mux live in the top module.

## Test plan
- Reset release, no events → all outputs 0 for 100 cycles. Timestamp check: an event injected at cycle 100 records `first_error_ts` = 100.
- Bit 6 high for 3 consecutive `ap_vld` cycles, then bit 9 once, with `irq_enable` = 16'h0040 → `error_sticky` = 16'h0240, `cnt_sel`=6 reads 3, `cnt_sel`=9 reads 1, `first_error` = 16'h0040, `irq` = 1.
- `protocol_error` = 16'hFFFF with `ap_vld` = 1 → `error_sticky` = 16'h33FF; `cnt_sel`=10 reads 0.
- `protocol_error` = 16'h0001 with `ap_vld` = 0 → no state change.
- `CNT_WIDTH` = 4, bit 0 asserted for 20 cycles → counter reads 15 (saturated).
- Same cycle: `clear_req` with `clear_mask` = 16'hFFFF and a bit-2 event → `error_sticky` = 16'h0004, counter2 = 1, `first_error` = 16'h0004 with a new timestamp, `first_error_valid` = 1. Partial clear 16'h0004 on the next cycle → record unchanged.
